// File: rtl/frequency_meter.sv
// Measures the period of an asynchronous square wave in system clock cycles
// and classifies it into one of the seven standard blink-timer frequencies.
//   state     | meaning
//   S_IDLE    | no reference edge yet (after reset or after a timeout)
//   S_MEASURE | counting cycles since the last rising edge
module frequency_meter #(
    parameter int PERIOD_100HZ   = 500000,
    parameter int TIMEOUT_CYCLES = 200 * PERIOD_100HZ,
    parameter int W              = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         signal_in,
    output logic         valid,
    output logic [W-1:0] period,
    output logic [2:0]   freq_code,
    output logic         timeout
);
    localparam int B = PERIOD_100HZ;
    localparam logic [W-1:0] TH_LO  = W'(B / 2);
    localparam logic [W-1:0] TH_100 = W'(3 * B / 2);
    localparam logic [W-1:0] TH_50  = W'(7 * B / 2);
    localparam logic [W-1:0] TH_20  = W'(15 * B / 2);
    localparam logic [W-1:0] TH_10  = W'(15 * B);
    localparam logic [W-1:0] TH_5   = W'(35 * B);
    localparam logic [W-1:0] TH_2   = W'(75 * B);
    localparam logic [W-1:0] TH_1   = W'(150 * B);
    localparam logic [W-1:0] T_MAX  = W'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_sync1;
    logic           r_sync2;
    logic           r_prev;
    logic [2:0]     r_fill;
    logic [W-1:0]   r_count;
    logic           r_valid;
    logic [W-1:0]   r_period;
    logic [2:0]     r_code;
    logic           r_timeout;
    logic [W-1:0]   w_count_nxt;
    logic           w_valid_nxt;
    logic [W-1:0]   w_period_nxt;
    logic [2:0]     w_code_nxt;
    logic           w_timeout_nxt;
    logic           w_edge;

    function automatic logic [2:0] classify(input logic [W-1:0] p);
        logic [2:0] code;
        code = 3'd0;
        if (p < TH_LO)       code = 3'd0;
        else if (p < TH_100) code = 3'd1;
        else if (p < TH_50)  code = 3'd2;
        else if (p < TH_20)  code = 3'd3;
        else if (p < TH_10)  code = 3'd4;
        else if (p < TH_5)   code = 3'd5;
        else if (p < TH_2)   code = 3'd6;
        else if (p < TH_1)   code = 3'd7;
        return code;
    endfunction

    // r_fill marks when r_prev holds a real sample, so an input that is
    // already high at reset release is not mistaken for a rising edge.
    assign w_edge = r_sync2 & ~r_prev & r_fill[2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 3'b000;
        end else begin
            r_sync1 <= signal_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[1:0], 1'b1};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_valid_nxt   = 1'b0;
        w_period_nxt  = r_period;
        w_code_nxt    = r_code;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_nxt   = S_MEASURE;
                    w_count_nxt   = W'(1);
                    w_timeout_nxt = 1'b0;
                end
            end
            S_MEASURE: begin
                // An edge on the terminal count still completes a measurement.
                if (w_edge) begin
                    w_period_nxt  = r_count;
                    w_code_nxt    = classify(r_count);
                    w_valid_nxt   = 1'b1;
                    w_count_nxt   = W'(1);
                    w_timeout_nxt = 1'b0;
                end else if (r_count == T_MAX) begin
                    w_timeout_nxt = 1'b1;
                    w_code_nxt    = 3'd0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_count_nxt = r_count + W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_period  <= '0;
            r_code    <= 3'd0;
            r_timeout <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_valid   <= w_valid_nxt;
            r_period  <= w_period_nxt;
            r_code    <= w_code_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign valid     = r_valid;
    assign period    = r_period;
    assign freq_code = r_code;
    assign timeout   = r_timeout;
endmodule

// File: tb/tb_frequency_meter.sv
// Scoreboard bench for frequency_meter: the driver predicts results from
// rising-edge times of signal_in; a monitor compares every cycle.
module tb_frequency_meter;
    localparam int B  = 50;
    localparam int TO = 200 * B;
    localparam int W  = $clog2(TO + 1);
    localparam int LAT = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         signal_in = 1'b0;
    logic         valid;
    logic [W-1:0] period;
    logic [2:0]   freq_code;
    logic         timeout;

    frequency_meter #(
        .PERIOD_100HZ(B),
        .TIMEOUT_CYCLES(TO),
        .W(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .signal_in(signal_in),
        .valid(valid),
        .period(period),
        .freq_code(freq_code),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int period;
        int code;
        int due;
    } exp_t;

    exp_t sb[$];
    int   rq[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   have_ref = 0;
    int   last_rise = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Bins from the frequency table: code k covers [ub[k-1], ub[k]).
    function automatic int ref_code(input int p);
        int ub[8];
        ub = '{B / 2, 3 * B / 2, 7 * B / 2, 15 * B / 2, 15 * B, 35 * B, 75 * B, 150 * B};
        if (p < ub[0] || p >= ub[7]) return 0;
        for (int k = 1; k < 8; k++) if (p < ub[k]) return k;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_rise();
        int   d;
        exp_t e;
        d = cyc - last_rise;
        if (have_ref != 0 && d <= TO) begin
            e.period = d;
            e.code   = ref_code(d);
            e.due    = cyc + LAT;
            sb.push_back(e);
        end
        have_ref  = 1;
        last_rise = cyc;
        rq.push_back(cyc);
    endtask

    task automatic rise_from_low(input int low_cycles);
        @(negedge clock);
        signal_in = 1'b0;
        repeat (low_cycles) @(negedge clock);
        signal_in = 1'b1;
        model_rise();
    endtask

    // Must be called straight after a rise: next rise lands gap cycles later.
    task automatic next_rise(input int gap);
        int lo;
        lo = gap / 2;
        if (lo > 40) lo = 40;
        if (lo < 1) lo = 1;
        repeat (lo) @(negedge clock);
        signal_in = 1'b0;
        repeat (gap - lo) @(negedge clock);
        signal_in = 1'b1;
        model_rise();
    endtask

    initial begin : monitor
        int   exp_period;
        int   exp_code;
        bit   prev_to;
        bit   exp_to;
        int   c;
        exp_t e;
        exp_period = 0;
        exp_code   = 0;
        prev_to    = 1'b0;
        forever begin
            @(negedge clock);
            c = cyc;
            if (reset) begin
                check("reset_valid", int'(valid), 0);
                check("reset_period", int'(period), 0);
                check("reset_freq_code", int'(freq_code), 0);
                check("reset_timeout", int'(timeout), 0);
                sb.delete();
                rq.delete();
                exp_period = 0;
                exp_code   = 0;
                prev_to    = 1'b0;
            end else begin
                while (rq.size() > 1 && rq[1] + LAT <= c) void'(rq.pop_front());
                exp_to = (rq.size() > 0 && rq[0] + LAT <= c && c - rq[0] >= TO + LAT);
                if (exp_to && !prev_to) exp_code = 0;
                prev_to = exp_to;
                if (valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", int'(valid), 0);
                    end else begin
                        e = sb.pop_front();
                        check("valid_cycle", c, e.due);
                        check("period", int'(period), e.period);
                        check("freq_code", int'(freq_code), e.code);
                        exp_period = e.period;
                        exp_code   = e.code;
                    end
                end else if (sb.size() > 0 && c > sb[0].due) begin
                    e = sb.pop_front();
                    check("missing_valid", int'(valid), 1);
                    exp_period = e.period;
                    exp_code   = e.code;
                end
                check("timeout", int'(timeout), int'(exp_to));
                check("period_hold", int'(period), exp_period);
                check("freq_code_hold", int'(freq_code), exp_code);
            end
        end
    end

    initial begin : driver
        #1 reset = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (20000) @(negedge clock);

        rise_from_low(20);
        repeat (8) next_rise(500);
        next_rise(74);
        next_rise(75);
        next_rise(24);
        next_rise(25);
        next_rise(7499);
        next_rise(7500);

        next_rise(50);
        next_rise(10200);
        next_rise(100);
        next_rise(10000);

        for (int i = 0; i < 30; i++) next_rise(int'($urandom_range(2, 900)));

        next_rise(400);
        repeat (300) @(negedge clock);
        #2 reset = 1'b1;
        have_ref = 0;
        #1;
        check("async_reset_valid", int'(valid), 0);
        check("async_reset_period", int'(period), 0);
        check("async_reset_freq_code", int'(freq_code), 0);
        check("async_reset_timeout", int'(timeout), 0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        rise_from_low(20);
        next_rise(333);
        next_rise(90);

        repeat (10) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
